// File: rtl/photo_adc_reader.sv
// Photo-sensor reader: periodic XADC DRP reads, 2**AVG_LOG2-sample average, 7-bit light level.
// Optional output hysteresis is enabled by defining ADC_HYST_EN.
//
// state  | meaning
// IDLE   | waiting for the sample timer tick
// REQ    | one-cycle DRP read request (drp_den high)
// WAIT   | waiting for drp_drdy, bounded by TIMEOUT
// ACC    | add latched sample into the accumulator
// AVG    | window complete: publish level, clear accumulator
module photo_adc_reader #(
  parameter int unsigned SAMPLE_DIV = 100_000,
  parameter int unsigned AVG_LOG2   = 3,
  parameter logic [6:0]  DRP_ADDR   = 7'h13,
  parameter int unsigned TIMEOUT    = 63,
  parameter int unsigned HYST       = 2
) (
  input  logic        clk,
  input  logic        reset_p,
  output logic        drp_den,
  output logic [6:0]  drp_daddr,
  output logic        drp_dwe,
  input  logic        drp_drdy,
  input  logic [15:0] drp_do,
  output logic [6:0]  adc_value,
  output logic        adc_valid,
  output logic        drp_err
);

  localparam int unsigned DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int unsigned TO_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int unsigned ACC_W = 12 + AVG_LOG2;
  localparam int unsigned CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;

  localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(SAMPLE_DIV - 1);
  localparam logic [TO_W-1:0]  TO_LOAD  = TO_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_ACC,
    S_AVG
  } state_t;

  state_t            state_q, state_d;
  logic [DIV_W-1:0]  timer_q, timer_d;
  logic [TO_W-1:0]   wait_q, wait_d;
  logic [11:0]       sample_q, sample_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [6:0]        value_q, value_d;
  logic              valid_q, valid_d;
  logic              err_q, err_d;

  logic              tick;
  logic [11:0]       avg12;
  logic [6:0]        new_lvl;

`ifdef ADC_HYST_EN
  localparam logic [7:0] HYST_L = 8'(HYST);
  logic              seen_q, seen_d;
  logic [6:0]        diff;
  logic              upd;
`endif

  assign drp_daddr = DRP_ADDR;
  assign drp_dwe   = 1'b0;
  assign drp_den   = (state_q == S_REQ);
  assign adc_value = value_q;
  assign adc_valid = valid_q;
  assign drp_err   = err_q;

  // Free-running down-counter; terminal count 0 is the tick, same phase as an up-count wrap.
  assign tick = (timer_q == '0);

  always_comb begin
    timer_d = tick ? DIV_LOAD : timer_q - DIV_W'(1);
  end

  assign avg12   = acc_q[AVG_LOG2 +: 12];
  assign new_lvl = avg12[11:5];

`ifdef ADC_HYST_EN
  always_comb begin
    diff = (new_lvl >= value_q) ? (new_lvl - value_q) : (value_q - new_lvl);
    upd  = !seen_q || (({1'b0, diff} >= HYST_L) && (new_lvl != value_q));
  end
`endif

  always_comb begin
    state_d  = state_q;
    wait_d   = wait_q;
    sample_d = sample_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    value_d  = value_q;
    valid_d  = 1'b0;
    err_d    = err_q;
`ifdef ADC_HYST_EN
    seen_d   = seen_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (tick) state_d = S_REQ;
      end
      S_REQ: begin
        wait_d  = TO_LOAD;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // drdy wins over an expiring wait counter in the same cycle
        if (drp_drdy) begin
          sample_d = drp_do[15:4];
          state_d  = S_ACC;
        end else if (wait_q == '0) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          wait_d = wait_q - TO_W'(1);
        end
      end
      S_ACC: begin
        acc_d   = acc_q + ACC_W'(sample_q);
        cnt_d   = cnt_q + CNT_W'(1);
        state_d = (cnt_q == CNT_LAST) ? S_AVG : S_IDLE;
      end
      S_AVG: begin
        acc_d   = '0;
        cnt_d   = '0;
        state_d = S_IDLE;
`ifdef ADC_HYST_EN
        if (upd) begin
          value_d = new_lvl;
          valid_d = 1'b1;
          seen_d  = 1'b1;
        end
`else
        value_d = new_lvl;
        valid_d = 1'b1;
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset_p) begin
      state_q  <= S_IDLE;
      timer_q  <= DIV_LOAD;
      wait_q   <= '0;
      sample_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      value_q  <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
`ifdef ADC_HYST_EN
      seen_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      wait_q   <= wait_d;
      sample_q <= sample_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      value_q  <= value_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
`ifdef ADC_HYST_EN
      seen_q   <= seen_d;
`endif
    end
  end

endmodule

// File: tb/tb_photo_adc_reader.sv
// Directed bench for photo_adc_reader with a behavioural DRP responder.
// Hysteresis expectations follow the ADC_HYST_EN define.
module tb_photo_adc_reader;

  localparam int SAMPLE_DIV = 16;
  localparam int AVG_LOG2   = 3;
  localparam int TIMEOUT    = 63;
  localparam int HYST       = 2;

  logic        clk = 1'b0;
  logic        reset_p = 1'b1;
  logic        drp_den, drp_dwe, drp_drdy;
  logic [6:0]  drp_daddr, adc_value;
  logic [15:0] drp_do;
  logic        adc_valid, drp_err;

  logic        m_drdy = 1'b0, t_drdy = 1'b0;
  logic [15:0] m_do = '0, t_do = '0;
  assign drp_drdy = m_drdy | t_drdy;
  assign drp_do   = m_do | t_do;

  int tests = 0;
  int fails = 0;

  bit          model_en = 1'b0;
  int          lat = 3, slow_idx = -1, slow_lat = 3, drop_idx = -1;
  logic [11:0] samp [0:31];
  logic [11:0] pend = '0;
  int          rd_idx = 0, cd = 0;

  int vcount = 0;
  bit prev_v = 1'b0, consec = 1'b0;

  photo_adc_reader #(
    .SAMPLE_DIV(SAMPLE_DIV), .AVG_LOG2(AVG_LOG2), .DRP_ADDR(7'h13),
    .TIMEOUT(TIMEOUT), .HYST(HYST)
  ) dut (
    .clk(clk), .reset_p(reset_p),
    .drp_den(drp_den), .drp_daddr(drp_daddr), .drp_dwe(drp_dwe),
    .drp_drdy(drp_drdy), .drp_do(drp_do),
    .adc_value(adc_value), .adc_valid(adc_valid), .drp_err(drp_err)
  );

  always #5 clk = ~clk;

  // DRP responder: drdy arrives 'lat' cycles after the den cycle
  always @(negedge clk) begin
    m_drdy = 1'b0;
    m_do   = '0;
    if (reset_p) begin
      rd_idx = 0;
      cd     = 0;
    end else begin
      if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          m_drdy = 1'b1;
          m_do   = {pend, 4'h0};
        end
      end
      if (model_en && drp_den === 1'b1) begin
        if (rd_idx != drop_idx) begin
          cd   = (rd_idx == slow_idx) ? slow_lat : lat;
          pend = samp[rd_idx % 32];
        end
        rd_idx++;
      end
    end
  end

  always @(negedge clk) begin
    if (adc_valid === 1'b1) begin
      vcount++;
      if (prev_v) consec = 1'b1;
    end
    prev_v = (adc_valid === 1'b1);
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset_p = 1'b1;
    repeat (3) @(negedge clk);
    reset_p = 1'b0;
  endtask

  task automatic wait_valid(output bit got, output logic [6:0] val);
    got = 1'b0;
    val = '0;
    for (int i = 0; i < 3000 && !got; i++) begin
      @(negedge clk);
      if (adc_valid === 1'b1) begin
        got = 1'b1;
        val = adc_value;
      end
    end
  endtask

  task automatic wait_den(output bit got);
    got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (drp_den === 1'b1) got = 1'b1;
    end
  endtask

  task automatic fill(input logic [11:0] v);
    for (int i = 0; i < 32; i++) samp[i] = v;
  endtask

  bit         got, early, den16;
  logic [6:0] val;
  int         v0, dens;

  initial begin
    fill(12'h000);

    // Reset state and constant outputs
    do_reset();
    check("rst_value", adc_value, 0);
    check("rst_valid", adc_valid, 0);
    check("rst_den", drp_den, 0);
    check("rst_err", drp_err, 0);
    check("daddr", drp_daddr, 7'h13);
    check("dwe", drp_dwe, 0);

    // Test 1: reset held 3 cycles mid-WAIT, late drdy ignored, timer restarts
    model_en = 1'b0;
    wait_den(got);
    check("t1_first_den", got, 1);
    repeat (2) @(negedge clk);
    reset_p = 1'b1;
    repeat (3) @(negedge clk);
    reset_p = 1'b0;
    check("t1_value", adc_value, 0);
    check("t1_valid", adc_valid, 0);
    check("t1_den", drp_den, 0);
    check("t1_err", drp_err, 0);
    v0 = vcount;
    early = 1'b0;
    den16 = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      if (k == 1) begin
        t_drdy = 1'b1;
        t_do   = 16'hFFF0;
      end else if (k == 2) begin
        t_drdy = 1'b0;
        t_do   = '0;
      end
      if (k < 16 && drp_den === 1'b1) early = 1'b1;
      if (k == 16) den16 = drp_den;
    end
    check("t1_no_early_den", early, 0);
    check("t1_den_at_16", den16, 1);
    check("t1_no_valid", vcount - v0, 0);
    check("t1_err_after", drp_err, 0);

    // Test 2: constant full-scale input
    model_en = 1'b1;
    lat = 3; slow_idx = -1; drop_idx = -1;
    fill(12'hFFF);
    do_reset();
    v0 = vcount;
    wait_valid(got, val);
    check("t2_valid_seen", got, 1);
    check("t2_value", val, 127);
    check("t2_reads", rd_idx, 8);
    check("t2_err", drp_err, 0);
    repeat (5) @(negedge clk);
    check("t2_one_pulse", vcount - v0, 1);

    // Test 3: ramp 0..3584 averages to 1792 -> 56
    for (int i = 0; i < 32; i++) samp[i] = 12'((i % 8) * 512);
    do_reset();
    v0 = vcount;
    wait_valid(got, val);
    check("t3_valid_seen", got, 1);
    check("t3_value", val, 56);
    repeat (20) @(negedge clk);
    check("t3_one_pulse", vcount - v0, 1);

    // Test 4: read #3 never answered -> timeout after TIMEOUT+1 WAIT cycles
    fill(12'd1024);
    samp[2] = 12'd0;
    drop_idx = 2;
    do_reset();
    dens = 0;
    for (int i = 0; i < 500 && dens < 3; i++) begin
      @(negedge clk);
      if (drp_den === 1'b1) dens++;
    end
    check("t4_third_den", dens, 3);
    repeat (TIMEOUT + 1) @(negedge clk);
    check("t4_err_not_yet", drp_err, 0);
    @(negedge clk);
    check("t4_err_set", drp_err, 1);
    wait_valid(got, val);
    check("t4_valid_seen", got, 1);
    check("t4_value", val, 32);
    check("t4_reads", rd_idx, 9);
    check("t4_err_sticky", drp_err, 1);
    drop_idx = -1;

    // Test 5: drdy on the last WAIT cycle is accepted
    fill(12'd2048);
    slow_idx = 1;
    slow_lat = TIMEOUT + 1;
    do_reset();
    wait_valid(got, val);
    check("t5_valid_seen", got, 1);
    check("t5_value", val, 64);
    check("t5_err", drp_err, 0);
    check("t5_reads", rd_idx, 8);

    // Test 5b: drdy one cycle too late -> timeout, stale data ignored
    samp[1] = 12'd0;
    slow_lat = TIMEOUT + 2;
    do_reset();
    wait_valid(got, val);
    check("t5b_valid_seen", got, 1);
    check("t5b_value", val, 64);
    check("t5b_err", drp_err, 1);
    check("t5b_reads", rd_idx, 9);
    slow_idx = -1;

    // Test 6: windows at levels 56, 57, 59
    for (int i = 0; i < 32; i++)
      samp[i] = (i < 8) ? 12'd1792 : (i < 16) ? 12'd1824 : 12'd1888;
    do_reset();
    v0 = vcount;
    wait_valid(got, val);
    check("t6_first_seen", got, 1);
    check("t6_first_value", val, 56);
`ifdef ADC_HYST_EN
    wait_valid(got, val);
    check("t6_hyst_seen", got, 1);
    check("t6_hyst_value", val, 59);
    check("t6_hyst_reads", rd_idx, 24);
    repeat (5) @(negedge clk);
    check("t6_hyst_pulses", vcount - v0, 2);
`else
    wait_valid(got, val);
    check("t6_second_seen", got, 1);
    check("t6_second_value", val, 57);
    wait_valid(got, val);
    check("t6_third_seen", got, 1);
    check("t6_third_value", val, 59);
    repeat (5) @(negedge clk);
    check("t6_pulses", vcount - v0, 3);
`endif

    check("valid_never_back_to_back", consec, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
